// File: rtl/dmem_responder.sv
// Data-memory responder: buffers word load/store requests in a small FIFO and
// services them in order after a fixed number of wait states.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int REQ_DEPTH   = 2,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_we,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int PTR_W = $clog2(REQ_DEPTH);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(REQ_DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [31:0] mem [2**ADDR_W];

  logic        fifo_we    [REQ_DEPTH];
  logic [31:0] fifo_addr  [REQ_DEPTH];
  logic [31:0] fifo_wdata [REQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              work_we;
  logic              work_err;
  logic [ADDR_W-1:0] work_idx;
  logic [31:0]       work_wdata;

  logic        push;
  logic        pop;
  logic [31:0] head_addr;
  logic        head_err;
  logic        last_access;
  logic        mem_write;

  // Readiness looks only at occupancy so it never combinationally depends on the consumer.
  assign req_ready   = !reset && (count != FULL_COUNT);
  assign push        = req_valid && req_ready;
  assign pop         = (state == IDLE) && (count != '0);
  assign head_addr   = fifo_addr[rd_ptr];
  assign head_err    = (head_addr[1:0] != 2'b00) || ((head_addr >> (ADDR_W + 2)) != 32'd0);
  assign last_access = (state == ACCESS) && (cnt == CNT_W'(1));
  assign mem_write   = !reset && last_access && work_we && !work_err;

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_we[wr_ptr]    <= req_we;
      fifo_addr[wr_ptr]  <= req_addr;
      fifo_wdata[wr_ptr] <= req_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left uninitialised by reset.
  always_ff @(posedge clock) begin
    if (mem_write) mem[work_idx] <= work_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      work_we    <= 1'b0;
      work_err   <= 1'b0;
      work_idx   <= '0;
      work_wdata <= '0;
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            work_we    <= fifo_we[rd_ptr];
            work_err   <= head_err;
            work_idx   <= head_addr[ADDR_W+1:2];
            work_wdata <= fifo_wdata[rd_ptr];
            cnt        <= CNT_W'(WAIT_CYCLES);
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt - CNT_W'(1);
          if (last_access) begin
            resp_valid <= 1'b1;
            resp_we    <= work_we;
            resp_err   <= work_err;
            resp_rdata <= (work_we || work_err) ? 32'd0 : mem[work_idx];
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table for single transactions,
// hand-written sequences for backpressure, push/pop overlap and mid-access reset.
module tb_dmem_responder;

  localparam int ADDR_W      = 8;
  localparam int REQ_DEPTH   = 2;
  localparam int WAIT_CYCLES = 2;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_we;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int num_compared;
  int num_mismatched;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  dmem_responder #(
    .ADDR_W(ADDR_W),
    .REQ_DEPTH(REQ_DEPTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_we(resp_we),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_compared++;
    if (act !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Offers one request and returns just after the accepting edge.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    @(negedge clock);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      compare("accept timeout", 32'(req_ready), 32'd1);
    end else begin
      @(posedge clock);
    end
    #1 req_valid = 1'b0;
  endtask

  // Waits for a response (resp_ready assumed high), checks it, and lets it handshake.
  task automatic checkOutput(input string name, input logic exp_we, input logic [31:0] exp_rdata,
                             input logic exp_err, output int lat);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!resp_valid && n < 40);
    lat = n - 1;
    if (!resp_valid) begin
      compare({name, " resp timeout"}, 32'(resp_valid), 32'd1);
    end else begin
      compare({name, " we"}, 32'(resp_we), 32'(exp_we));
      compare({name, " rdata"}, resp_rdata, exp_rdata);
      compare({name, " err"}, 32'(resp_err), 32'(exp_err));
      @(posedge clock);
    end
  endtask

  initial begin
    int lat;
    int got;
    int seen;
    logic accepted;
    logic drop;
    logic [31:0] exp_q[4];

    num_compared   = 0;
    num_mismatched = 0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         32'h0, 1'b1};
    vecs[3]  = '{1'b0, 32'h0000_0400, 32'h0,         32'h0, 1'b1};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'h0000_0005, 32'h0, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0402, 32'hFFFF_FFFF, 32'h0, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0005, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_03FC, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0004, 32'h0BAD_F00D, 32'h0, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0020, 32'h0,         32'h0, 1'b0};
    vecs[11] = '{1'b1, 32'h8000_0010, 32'h1111_1111, 32'h0, 1'b1};
    vecs[12] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_0004, 32'h0,         32'h0BAD_F00D, 1'b0};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;

    repeat (3) @(negedge clock);
    compare("reset req_ready", 32'(req_ready), 32'd0);
    compare("reset resp_valid", 32'(resp_valid), 32'd0);
    compare("reset resp_we", 32'(resp_we), 32'd0);
    compare("reset resp_err", 32'(resp_err), 32'd0);
    compare("reset resp_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    compare("post-reset req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d", i), vecs[i].we, vecs[i].exp_rdata, vecs[i].exp_err, lat);
      // Accept edge E0 to resp_valid takes 1 + WAIT_CYCLES edges from an idle start.
      if (i == 0) compare("vec0 latency", 32'(lat), 32'(1 + WAIT_CYCLES));
    end

    // Backpressure: four loads against a stalled consumer.
    exp_q = '{32'hDEAD_BEEF, 32'h0000_0005, 32'hA5A5_A5A5, 32'h0BAD_F00D};
    @(negedge clock);
    resp_ready = 1'b0;
    req_we     = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h10;
    compare("bp ready A", 32'(req_ready), 32'd1);
    @(negedge clock);
    req_addr = 32'h0;
    compare("bp ready B", 32'(req_ready), 32'd1);
    @(negedge clock);
    req_addr = 32'h3FC;
    compare("bp ready C", 32'(req_ready), 32'd1);
    @(negedge clock);
    req_addr = 32'h4;
    compare("bp full ready", 32'(req_ready), 32'd0);
    seen = 0;
    while (!resp_valid && seen < 20) begin
      @(negedge clock);
      seen++;
    end
    for (int c = 0; c < 10; c++) begin
      compare("bp hold valid", 32'(resp_valid), 32'd1);
      compare("bp hold rdata", resp_rdata, 32'hDEAD_BEEF);
      compare("bp hold ready", 32'(req_ready), 32'd0);
      @(negedge clock);
    end
    resp_ready = 1'b1;
    got  = 0;
    drop = 1'b0;
    for (int c = 0; c < 80 && got < 4; c++) begin
      if (drop) req_valid = 1'b0;
      accepted = req_valid && req_ready;
      if (resp_valid) begin
        compare($sformatf("bp resp%0d rdata", got), resp_rdata, exp_q[got]);
        compare($sformatf("bp resp%0d err", got), 32'(resp_err), 32'd0);
        got++;
      end
      @(negedge clock);
      drop = accepted;
    end
    req_valid = 1'b0;
    compare("bp resp count", 32'(got), 32'd4);
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (resp_valid) seen++;
    end
    compare("bp no extra resp", 32'(seen), 32'd0);

    // Push on the same edge the FSM pops the only entry.
    req_valid = 1'b1;
    req_addr  = 32'h10;
    @(negedge clock);
    req_addr = 32'h0;
    @(negedge clock);
    compare("pushpop ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 40 && got < 2; c++) begin
      if (resp_valid) begin
        compare($sformatf("pushpop resp%0d rdata", got), resp_rdata, exp_q[got]);
        got++;
      end
      @(negedge clock);
    end
    compare("pushpop resp count", 32'(got), 32'd2);
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (resp_valid) seen++;
    end
    compare("pushpop no extra resp", 32'(seen), 32'd0);

    // Reset while a store is in ACCESS with a load still queued behind it.
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h1234_5678;
    req_valid = 1'b1;
    @(negedge clock);
    req_we   = 1'b0;
    req_addr = 32'h10;
    @(negedge clock);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clock);
    compare("midreset resp_valid", 32'(resp_valid), 32'd0);
    compare("midreset req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    compare("after reset req_ready", 32'(req_ready), 32'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (resp_valid) seen++;
    end
    compare("after reset no resp", 32'(seen), 32'd0);
    applyStimulus(1'b0, 32'h20, 32'h0);
    checkOutput("reload 0x20", 1'b0, 32'h0, 1'b0, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage load/store traffic, i.e. the target end of the data-memory interface.
- Accepts word load/store requests through a valid/ready handshake into a small request FIFO.
- Services requests in order with a configurable wait-state count.
- Returns one response per request (load data, or store acknowledge) through a second valid/ready handshake. Lets the core run against slow memory instead of a zero-latency array.

Parameters:
ADDR_W, 8, word-address width; storage depth is 2**ADDR_W 32-bit words
REQ_DEPTH, 2, request FIFO entries (power of two, >=2)
WAIT_CYCLES, 2, access cycles per request (>=1)

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  FIFO can accept; high when FIFO count < REQ_DEPTH and reset low
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_we  output  1  echo of req_we for this response
resp_rdata  output  32  load data; 0 for stores and errors
resp_err  output  1  address misaligned or out of range

Behaviour:
- Interface decision: one clock (clock); reset is synchronous and active-high (reset).
- Reset values:
  - FIFO is empty and state is IDLE.
  - resp_valid, resp_we and resp_err are 0; resp_rdata is 0.
  - req_ready is 0 while reset is high and 1 on the first cycle after.
  - Storage array is not cleared.
- Accept: the request is pushed at the rising edge where req_valid && req_ready. req_ready depends on FIFO count only, never on same-cycle pop or resp_ready. A push and a pop on the same edge leave the count unchanged.
- Error check at pop:
  - err = (req_addr[1:0] != 0) || (req_addr[31:ADDR_W+2] != 0).
  - Word index = req_addr[ADDR_W+1:2].
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head into working registers, set cnt = WAIT_CYCLES, go to ACCESS. Otherwise stay.
  - ACCESS: cnt decrements each edge. On the edge where cnt == 1:
    - Store without err: write mem[index].
    - Load without err: capture mem[index] into resp_rdata.
    - Store or err: resp_rdata = 0.
    - Set resp_valid = 1 and resp_we and resp_err from the working registers. Go to RESP.
  - RESP: resp_valid, resp_we, resp_rdata and resp_err are held stable until resp_valid && resp_ready. On that edge, clear resp_valid and go to IDLE.
- Latency: a request accepted at edge E0 with an empty FIFO and state IDLE has resp_valid high from edge E0+1+WAIT_CYCLES. With WAIT_CYCLES=2 that is E0+3. Back-to-back requests add one IDLE cycle between a response handshake and the next pop.
- Ordering: responses are strictly in acceptance order. A load following a store to the same address returns the stored data.
- Errored stores do not modify storage.
- FIFO full: req_ready = 0 and req_valid is ignored. Pointers wrap modulo REQ_DEPTH.
- Backpressure: while in RESP with resp_ready low, the FIFO keeps accepting until full. No response is dropped or overwritten.
- Reset mid-operation:
  - Pending FIFO entries and any in-flight request are discarded.
  - A store still in ACCESS at the reset edge is not written.
  - resp_valid drops on the reset edge.

Test Plan:
- Store then load: store 0xDEADBEEF to 0x10, then load 0x10, resp_ready=1, WAIT_CYCLES=2 → store response (resp_we=1, rdata=0, err=0) 3 cycles after accept; then load response rdata=0xDEADBEEF, err=0.
- Errors: load 0x13 (misaligned) and load 0x400 (out of range for ADDR_W=8) → resp_err=1, rdata=0. A store to 0x402 leaves mem[0] unchanged; verify with a load of 0x0 after writing 0x5 there.
- Backpressure/full: hold resp_ready=0 and offer 4 loads back-to-back → the first is popped, 2 more fill the FIFO, req_ready=0 with the 4th still pending. resp_valid and data stay stable for 10 cycles. Release resp_ready → all 4 responses arrive in order with correct data.
- Simultaneous push/pop: with the FIFO at count 1 and the FSM popping in IDLE, push on the same edge → count stays 1 and no request is lost or duplicated.
- Reset mid-store: accept a store of 0x12345678 to 0x20 (mem[0x20] previously 0x0), assert reset during ACCESS → resp_valid=0 next cycle, FIFO empty, req_ready=1 after reset; a subsequent load of 0x20 returns 0x0.
